// File: rtl/lookup_type_pkg.sv
// Shared widths and record types for the pipelined type-lookup stage.
// The rule record layout is fixed here; the top-level width parameters must agree with it.
package lookup_type_pkg;

  localparam int LT_TYPE_NUM          = 4;
  localparam int LT_TYPE_WIDTH        = 16;
  localparam int LT_RULE_NUM          = 16;
  localparam int LT_TYPE_OFFSET_WIDTH = 8;
  localparam int LT_KEY_FIELD_NUM     = 8;
  localparam int LT_KEY_OFFSET_WIDTH  = 6;
  localparam int LT_HEAD_SHIFT_WIDTH  = 6;
  localparam int LT_META_SHIFT_WIDTH  = 6;
  localparam int LT_TAG_WIDTH         = 8;
  localparam int LT_CNT_WIDTH         = 16;

  localparam int RULE_IDX_W  = $clog2(LT_RULE_NUM);
  localparam int KEY_ENTRY_W = LT_KEY_OFFSET_WIDTH + 1;

endpackage

// File: rtl/lookup_type_rules_pkg.sv
// Rule and result records for the type-lookup stage, built on lookup_type_pkg widths.
package lookup_type_rules_pkg;
  import lookup_type_pkg::*;

  // Everything except the valid bit; the valid bit lives in a reset register in the top.
  typedef struct packed {
    logic [LT_TYPE_NUM-1:0][LT_TYPE_WIDTH-1:0]        typeData;
    logic [LT_TYPE_NUM-1:0][LT_TYPE_WIDTH-1:0]        typeMask;
    logic [LT_TYPE_NUM-1:0][LT_TYPE_OFFSET_WIDTH-1:0] typeOffset;
    logic [LT_KEY_FIELD_NUM-1:0][KEY_ENTRY_W-1:0]     keyOffset;
    logic [LT_HEAD_SHIFT_WIDTH-1:0]                   headShift;
    logic [LT_META_SHIFT_WIDTH-1:0]                   metaShift;
  } rule_body_t;

  typedef struct packed {
    logic       valid;
    rule_body_t body;
  } rule_t;

endpackage

// File: rtl/prio_onehot_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and any-request flag.
module prio_onehot_enc #(
  parameter int N = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Isolate the lowest set bit.
  assign grant = req & (~req + N'(1));
  assign any   = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lookup_type_pipe.sv
// Two-stage masked type lookup against a configurable rule table, with valid/ready flow
// control, a config-write interlock and saturating per-rule hit / miss counters.
module lookup_type_pipe
  import lookup_type_pkg::*;
  import lookup_type_rules_pkg::*;
#(
  parameter int TYPE_NUM          = LT_TYPE_NUM,
  parameter int TYPE_WIDTH        = LT_TYPE_WIDTH,
  parameter int RULE_NUM          = LT_RULE_NUM,
  parameter int TYPE_OFFSET_WIDTH = LT_TYPE_OFFSET_WIDTH,
  parameter int KEY_FIELD_NUM     = LT_KEY_FIELD_NUM,
  parameter int KEY_OFFSET_WIDTH  = LT_KEY_OFFSET_WIDTH,
  parameter int HEAD_SHIFT_WIDTH  = LT_HEAD_SHIFT_WIDTH,
  parameter int META_SHIFT_WIDTH  = LT_META_SHIFT_WIDTH,
  parameter int TAG_WIDTH         = LT_TAG_WIDTH,
  parameter int CNT_WIDTH         = LT_CNT_WIDTH,
  parameter int PRIORITY_MODE     = 1
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic                                          i_valid,
  output logic                                          o_ready,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_type,
  input  logic [TAG_WIDTH-1:0]                          i_tag,
  output logic                                          o_valid,
  input  logic                                          i_ready,
  output logic                                          o_hit,
  output logic [$clog2(RULE_NUM)-1:0]                   o_ruleIdx,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         o_typeOffset,
  output logic [KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_keyOffset,
  output logic [HEAD_SHIFT_WIDTH-1:0]                   o_headShift,
  output logic [META_SHIFT_WIDTH-1:0]                   o_metaShift,
  output logic [TAG_WIDTH-1:0]                          o_tag,
  input  logic                                          i_cfg_valid,
  output logic                                          o_cfg_ready,
  input  logic [$clog2(RULE_NUM)-1:0]                   i_cfg_addr,
  input  rule_t                                         i_cfg_rule,
  input  logic [$clog2(RULE_NUM):0]                     i_cnt_rdaddr,
  output logic [CNT_WIDTH-1:0]                          o_cnt_rddata,
  input  logic                                          i_cnt_clr
);

  localparam int IDX_W = $clog2(RULE_NUM);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rule_body_t                                   rule_data [RULE_NUM];
  logic [RULE_NUM-1:0]                          rule_vld;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          type_a;
  logic [RULE_NUM-1:0]                          hit_c;
  logic                                         vld_p1, vld_p2;
  logic [RULE_NUM-1:0]                          hit_p1;
  logic [TAG_WIDTH-1:0]                         tag_p1;
  logic                                         adv_p1, adv_p2;
  logic                                         cfg_fire, out_fire;
  logic [RULE_NUM-1:0]                          grant_p1, sel_vec;
  logic [IDX_W-1:0]                             idx_p1;
  logic                                         any_p1;
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]   toff_sel;
  logic [KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)-1:0] key_sel;
  logic [HEAD_SHIFT_WIDTH-1:0]                  hs_sel;
  logic [META_SHIFT_WIDTH-1:0]                  ms_sel;
  logic [CNT_WIDTH-1:0]                         hit_cnt [RULE_NUM];
  logic [CNT_WIDTH-1:0]                         miss_cnt;
  logic [CNT_WIDTH-1:0]                         rd_c;

  assign type_a   = i_type;
  assign adv_p2   = ~vld_p2 | i_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign o_ready  = adv_p1;
  assign o_valid  = vld_p2;
  assign out_fire = vld_p2 & i_ready;

  // A rule that S1 has matched may not be rewritten until that lookup has left S1.
  assign o_cfg_ready = ~(vld_p1 & hit_p1[i_cfg_addr]);
  assign cfg_fire    = i_cfg_valid & o_cfg_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_vld <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (cfg_fire && i_cfg_addr == IDX_W'(r)) rule_vld[r] <= i_cfg_rule.valid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < RULE_NUM; r++) begin
      if (cfg_fire && i_cfg_addr == IDX_W'(r)) rule_data[r] <= i_cfg_rule.body;
    end
  end

  always_comb begin
    hit_c = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      hit_c[r] = rule_vld[r];
      for (int j = 0; j < TYPE_NUM; j++) begin
        if ((rule_data[r].typeMask[j] & type_a[j]) != rule_data[r].typeData[j]) hit_c[r] = 1'b0;
      end
    end
  end

  // ---- S1: match vector and tag ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (adv_p1 && i_valid) begin
      hit_p1 <= hit_c;
      tag_p1 <= i_tag;
    end
  end

  prio_onehot_enc #(.N(RULE_NUM)) u_enc (
    .req   (hit_p1),
    .grant (grant_p1),
    .idx   (idx_p1),
    .any   (any_p1)
  );

  // Legacy mode merges every hit rule; the index is still the lowest hit.
  assign sel_vec = (PRIORITY_MODE != 0) ? grant_p1 : hit_p1;

  always_comb begin
    toff_sel = '0;
    key_sel  = '0;
    hs_sel   = '0;
    ms_sel   = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (sel_vec[r]) begin
        toff_sel = toff_sel | rule_data[r].typeOffset;
        key_sel  = key_sel  | rule_data[r].keyOffset;
        hs_sel   = hs_sel   | rule_data[r].headShift;
        ms_sel   = ms_sel   | rule_data[r].metaShift;
      end
    end
  end

  // ---- S2: registered result ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p2       <= 1'b0;
      o_hit        <= 1'b0;
      o_ruleIdx    <= '0;
      o_typeOffset <= '0;
      o_keyOffset  <= '0;
      o_headShift  <= '0;
      o_metaShift  <= '0;
      o_tag        <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        o_hit        <= any_p1;
        o_ruleIdx    <= idx_p1;
        o_typeOffset <= toff_sel;
        o_keyOffset  <= key_sel;
        o_headShift  <= hs_sel;
        o_metaShift  <= ms_sel;
        o_tag        <= tag_p1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) hit_cnt[r] <= '0;
      miss_cnt <= '0;
    end else if (i_cnt_clr) begin
      for (int r = 0; r < RULE_NUM; r++) hit_cnt[r] <= '0;
      miss_cnt <= '0;
    end else if (out_fire) begin
      if (o_hit) hit_cnt[o_ruleIdx] <= sat_inc(hit_cnt[o_ruleIdx]);
      else       miss_cnt           <= sat_inc(miss_cnt);
    end
  end

  always_comb begin
    rd_c = '0;
    for (int k = 0; k < RULE_NUM; k++) begin
      if (i_cnt_rdaddr == (IDX_W+1)'(k)) rd_c = hit_cnt[k];
    end
    if (i_cnt_rdaddr == (IDX_W+1)'(RULE_NUM)) rd_c = miss_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_cnt_rddata <= '0;
    else          o_cnt_rddata <= rd_c;
  end

endmodule

// File: tb/tb_lookup_type_pipe.sv
// Directed bench for lookup_type_pipe: a priority-mode instance and a legacy OR-merge instance share stimulus.
`timescale 1ns/1ps
module tb_lookup_type_pipe;
  import lookup_type_pkg::*;
  import lookup_type_rules_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_ready = 1'b1, i_cfg_valid = 1'b0, i_cnt_clr = 1'b0;
  logic [63:0] i_type = '0;
  logic [7:0]  i_tag = '0;
  logic [3:0]  i_cfg_addr = '0;
  rule_t       i_cfg_rule = '0;
  logic [4:0]  i_cnt_rdaddr = '0;

  logic        o_ready, o_valid, o_hit, o_cfg_ready;
  logic [3:0]  o_ruleIdx;
  logic [31:0] o_typeOffset;
  logic [55:0] o_keyOffset;
  logic [5:0]  o_headShift, o_metaShift;
  logic [7:0]  o_tag;
  logic [15:0] o_cnt_rddata;

  logic        m0_ready, m0_valid, m0_hit, m0_cfg_ready;
  logic [3:0]  m0_ruleIdx;
  logic [31:0] m0_typeOffset;
  logic [55:0] m0_keyOffset;
  logic [5:0]  m0_headShift, m0_metaShift;
  logic [7:0]  m0_tag;
  logic [15:0] m0_cnt_rddata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lookup_type_pipe #(.PRIORITY_MODE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_type(i_type),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_hit(o_hit), .o_ruleIdx(o_ruleIdx),
    .o_typeOffset(o_typeOffset), .o_keyOffset(o_keyOffset), .o_headShift(o_headShift),
    .o_metaShift(o_metaShift), .o_tag(o_tag), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_addr(i_cfg_addr), .i_cfg_rule(i_cfg_rule), .i_cnt_rdaddr(i_cnt_rdaddr),
    .o_cnt_rddata(o_cnt_rddata), .i_cnt_clr(i_cnt_clr)
  );

  lookup_type_pipe #(.PRIORITY_MODE(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(m0_ready), .i_type(i_type),
    .i_tag(i_tag), .o_valid(m0_valid), .i_ready(i_ready), .o_hit(m0_hit), .o_ruleIdx(m0_ruleIdx),
    .o_typeOffset(m0_typeOffset), .o_keyOffset(m0_keyOffset), .o_headShift(m0_headShift),
    .o_metaShift(m0_metaShift), .o_tag(m0_tag), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(m0_cfg_ready),
    .i_cfg_addr(i_cfg_addr), .i_cfg_rule(i_cfg_rule), .i_cnt_rdaddr(i_cnt_rdaddr),
    .o_cnt_rddata(m0_cnt_rddata), .i_cnt_clr(i_cnt_clr)
  );

  function automatic rule_t mk_rule(input logic [15:0] d, input logic [15:0] m, input logic [5:0] hs,
                                    input logic [5:0] ms, input logic [7:0] to0, input logic [6:0] k0);
    rule_t r;
    r = '0;
    r.valid = 1'b1;
    r.body.typeData[0]   = d;
    r.body.typeMask[0]   = m;
    r.body.headShift     = hs;
    r.body.metaShift     = ms;
    r.body.typeOffset[0] = to0;
    r.body.keyOffset[0]  = k0;
    return r;
  endfunction

  task automatic wr_rule(input logic [3:0] a, input rule_t r);
    int waited;
    i_cfg_valid = 1'b1;
    i_cfg_addr  = a;
    i_cfg_rule  = r;
    #1;
    waited = 0;
    while (!o_cfg_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (!o_cfg_ready) begin
      bad++;
      $display("FAIL cfg_write_timeout addr=%0d o_cfg_ready=%b want 1", a, o_cfg_ready);
    end
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
  endtask

  task automatic send_lookup(input logic [15:0] t0, input logic [7:0] tag);
    i_valid = 1'b1;
    i_type  = {48'h0, t0};
    i_tag   = tag;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic rd_cnt(input logic [4:0] a, output logic [15:0] v);
    i_cnt_rdaddr = a;
    @(posedge clk); #1;
    v = o_cnt_rddata;
  endtask

  task automatic pulse_clr();
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL reset_o_hit got %b want 0", o_hit); end
    total++; if (o_ruleIdx !== 4'd0 || o_headShift !== 6'd0 || o_tag !== 8'd0) begin
      bad++; $display("FAIL reset_data idx=%0d hs=%0d tag=%0d want 0", o_ruleIdx, o_headShift, o_tag);
    end
    total++; if (o_cnt_rddata !== 16'd0) begin bad++; $display("FAIL reset_rddata got %h want 0", o_cnt_rddata); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1 || o_cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready o_ready=%b o_cfg_ready=%b want 1 1", o_ready, o_cfg_ready);
    end
  endtask

  task automatic test_single_hit();
    wr_rule(4'd3, mk_rule(16'h0800, 16'hFFFF, 6'd14, 6'd0, 8'h00, 7'h00));
    send_lookup(16'h0800, 8'hA1);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL latency_early o_valid got %b want 0", o_valid); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_hit !== 1'b1) begin
      bad++; $display("FAIL single_hit valid=%b hit=%b want 1 1", o_valid, o_hit);
    end
    total++; if (o_ruleIdx !== 4'd3) begin bad++; $display("FAIL single_idx got %0d want 3", o_ruleIdx); end
    total++; if (o_headShift !== 6'd14) begin bad++; $display("FAIL single_hs got %0d want 14", o_headShift); end
    total++; if (o_tag !== 8'hA1) begin bad++; $display("FAIL single_tag got %h want a1", o_tag); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_drain o_valid got %b want 0", o_valid); end
  endtask

  task automatic test_priority();
    wr_rule(4'd2, mk_rule(16'h1234, 16'hFFFF, 6'd5, 6'd1, 8'h10, 7'h00));
    wr_rule(4'd5, mk_rule(16'h1200, 16'hFF00, 6'd10, 6'd2, 8'h03, 7'h41));
    send_lookup(16'h1234, 8'hB2);
    @(posedge clk); #1;
    total++; if (o_ruleIdx !== 4'd2 || o_headShift !== 6'd5 || o_metaShift !== 6'd1) begin
      bad++; $display("FAIL prio1_fields idx=%0d hs=%0d ms=%0d want 2 5 1", o_ruleIdx, o_headShift, o_metaShift);
    end
    total++; if (o_typeOffset !== 32'h10 || o_keyOffset !== 56'h0) begin
      bad++; $display("FAIL prio1_offsets toff=%h key=%h want 10 0", o_typeOffset, o_keyOffset);
    end
    total++; if (m0_hit !== 1'b1 || m0_ruleIdx !== 4'd2 || m0_headShift !== 6'd15 || m0_metaShift !== 6'd3) begin
      bad++; $display("FAIL prio0_fields hit=%b idx=%0d hs=%0d ms=%0d want 1 2 15 3", m0_hit, m0_ruleIdx, m0_headShift, m0_metaShift);
    end
    total++; if (m0_typeOffset !== 32'h13 || m0_keyOffset !== 56'h41) begin
      bad++; $display("FAIL prio0_offsets toff=%h key=%h want 13 41", m0_typeOffset, m0_keyOffset);
    end
    send_lookup(16'h12AB, 8'hB3);
    @(posedge clk); #1;
    total++; if (o_ruleIdx !== 4'd5 || o_headShift !== 6'd10 || m0_headShift !== 6'd10 || o_keyOffset !== 56'h41) begin
      bad++; $display("FAIL rule5_only idx=%0d hs=%0d m0hs=%0d key=%h want 5 10 10 41", o_ruleIdx, o_headShift, m0_headShift, o_keyOffset);
    end
  endtask

  task automatic test_miss_counter();
    logic [15:0] v;
    pulse_clr();
    rd_cnt(5'd16, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL miss_after_clr got %h want 0", v); end
    send_lookup(16'hBEEF, 8'hC1);
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_hit !== 1'b0 || o_ruleIdx !== 4'd0) begin
      bad++; $display("FAIL miss_result valid=%b hit=%b idx=%0d want 1 0 0", o_valid, o_hit, o_ruleIdx);
    end
    total++; if (o_typeOffset !== 32'h0 || o_keyOffset !== 56'h0 || o_headShift !== 6'd0 || o_metaShift !== 6'd0) begin
      bad++; $display("FAIL miss_fields toff=%h key=%h hs=%0d ms=%0d want all 0", o_typeOffset, o_keyOffset, o_headShift, o_metaShift);
    end
    @(posedge clk); #1;
    rd_cnt(5'd16, v);
    total++; if (v !== 16'd1) begin bad++; $display("FAIL miss_count got %h want 1", v); end
    rd_cnt(5'd17, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL rd_out_of_range got %h want 0", v); end
    rd_cnt(5'd3, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL rule3_cnt_after_clr got %h want 0", v); end
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    logic stalled;
    logic [7:0] held;
    sent = 0; recv = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      i_ready = (cyc < 3 || cyc >= 8);
      i_valid = (sent < 4);
      i_type  = {48'h0, 16'h0800};
      i_tag   = 8'(sent);
      #1;
      if (cyc == 2) begin
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_c2 got %b want 1", o_ready); end
      end
      if (cyc == 3) begin
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got %b want 0", o_ready); end
      end
      if (stalled) begin
        total++; if (o_valid !== 1'b1 || o_tag !== held) begin
          bad++; $display("FAIL b2b_hold valid=%b tag=%0d want 1 %0d", o_valid, o_tag, held);
        end
      end
      stalled = o_valid & ~i_ready;
      held    = o_tag;
      if (o_valid && i_ready) begin
        total++;
        if (recv >= 4) begin
          bad++; $display("FAIL b2b_duplicate tag=%0d recv=%0d want none", o_tag, recv);
        end else if (o_tag !== 8'(recv) || o_hit !== 1'b1) begin
          bad++; $display("FAIL b2b_order tag=%0d hit=%b want %0d 1", o_tag, o_hit, recv);
        end
        recv++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    total++; if (recv != 4 || sent != 4) begin bad++; $display("FAIL b2b_count recv=%0d sent=%0d want 4 4", recv, sent); end
  endtask

  task automatic test_interlock();
    send_lookup(16'h0800, 8'hD1);
    i_cfg_valid = 1'b0;
    i_cfg_addr  = 4'd7;
    #1;
    total++; if (o_cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_nonhit_ready got %b want 1", o_cfg_ready); end
    i_cfg_addr  = 4'd3;
    i_cfg_rule  = mk_rule(16'h0800, 16'hFFFF, 6'd20, 6'd0, 8'h00, 7'h00);
    i_cfg_valid = 1'b1;
    #1;
    total++; if (o_cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_interlock got %b want 0", o_cfg_ready); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_headShift !== 6'd14) begin
      bad++; $display("FAIL interlock_old_fields valid=%b hs=%0d want 1 14", o_valid, o_headShift);
    end
    total++; if (o_cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_release got %b want 1", o_cfg_ready); end
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
    send_lookup(16'h0800, 8'hD2);
    @(posedge clk); #1;
    total++; if (o_headShift !== 6'd20 || o_ruleIdx !== 4'd3) begin
      bad++; $display("FAIL interlock_new_fields hs=%0d idx=%0d want 20 3", o_headShift, o_ruleIdx);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] v;
    wr_rule(4'd0, mk_rule(16'h00AA, 16'hFFFF, 6'd1, 6'd1, 8'h00, 7'h00));
    pulse_clr();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_type  = {48'h0, 16'h00AA};
    i_tag   = 8'h55;
    repeat (65537) @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_cnt(5'd0, v);
    total++; if (v !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate got %h want ffff", v); end
    rd_cnt(5'd16, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL cnt_sat_miss got %h want 0", v); end
  endtask

  task automatic test_clr_with_hit();
    logic [15:0] v;
    send_lookup(16'h00AA, 8'hE1);
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_ruleIdx !== 4'd0) begin
      bad++; $display("FAIL clr_hit_setup valid=%b idx=%0d want 1 0", o_valid, o_ruleIdx);
    end
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    rd_cnt(5'd0, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL clr_beats_inc got %h want 0", v); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] v;
    send_lookup(16'h0800, 8'hF0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_cnt(5'd3, v);
    total++; if (v !== 16'd1) begin bad++; $display("FAIL pre_reset_cnt got %h want 1", v); end
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_type  = {48'h0, 16'h0800};
    i_tag   = 8'hF1;
    @(posedge clk); #1;
    i_tag   = 8'hF2;
    @(posedge clk); #1;
    i_valid = 1'b0;
    #1;
    total++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      bad++; $display("FAIL full_before_reset valid=%b ready=%b want 1 0", o_valid, o_ready);
    end
    rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_hit !== 1'b0 || o_cnt_rddata !== 16'd0) begin
      bad++; $display("FAIL async_reset valid=%b hit=%b rd=%h want 0 0 0", o_valid, o_hit, o_cnt_rddata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL discarded_emitted cycle=%0d valid=%b want 0", k, o_valid); end
    end
    rd_cnt(5'd3, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL post_reset_cnt got %h want 0", v); end
    send_lookup(16'h0800, 8'hF3);
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1 || o_hit !== 1'b0) begin
      bad++; $display("FAIL post_reset_rule_invalid valid=%b hit=%b want 1 0", o_valid, o_hit);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_priority();
    test_miss_counter();
    test_back_to_back();
    test_interlock();
    test_saturation();
    test_clr_with_hit();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
